bit_balance_counter: RTL and testbench

BIT_BALANCE_COUNTER -- requirements
Module: bit_balance_counter

---
 rtl/bit_balance_counter_pkg.sv | 16 +
 rtl/bit_balance_counter_if.sv | 36 +++
 rtl/bit_balance_counter_popcount_chunk.sv | 21 ++
 rtl/bit_balance_counter.sv | 156 +++++++++++++++
 tb/tb_bit_balance_counter.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/bit_balance_counter_pkg.sv
// Shared types for the bit balance counter.
// FSM state encoding and count-width helper.
package bit_balance_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bits needed to hold any count from 0 to w inclusive.
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/bit_balance_counter_if.sv
// Valid/ready bus of the bit balance counter.
// master drives words in and consumes results; slave is the counter.
interface bit_balance_counter_if #(
    parameter int WIDTH = 16,
    parameter int ACC_W = 16
);
    import bit_balance_pkg::*;

    localparam int CW = cnt_w(WIDTH);

    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        in_data;
    logic                    clr_acc;
    logic                    out_valid;
    logic                    out_ready;
    logic [CW-1:0]           ones;
    logic [CW-1:0]           zeros;
    logic [CW-1:0]           diff;
    logic                    zeros_gt;
    logic signed [ACC_W-1:0] run_disp;
    logic                    sat;

    modport master (
        output in_valid, in_data, clr_acc, out_ready,
        input  in_ready, out_valid, ones, zeros, diff,
        input  zeros_gt, run_disp, sat
    );

    modport slave (
        input  in_valid, in_data, clr_acc, out_ready,
        output in_ready, out_valid, ones, zeros, diff,
        output zeros_gt, run_disp, sat
    );

endinterface

// File: rtl/bit_balance_counter_popcount_chunk.sv
// Combinational ones counter for one CHUNK-bit slice.
// Result width is just wide enough for CHUNK.
module popcount_chunk
    import bit_balance_pkg::*;
#(
    parameter int CHUNK = 4,
    parameter int PW    = cnt_w(CHUNK)
) (
    input  logic [CHUNK-1:0] bits_i,
    output logic [PW-1:0]    cnt_o
);

    // Sum the bits of the slice.
    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < CHUNK; i++) begin
            cnt_o = cnt_o + PW'(bits_i[i]);
        end
    end

endmodule

// File: rtl/bit_balance_counter.sv
// Multi-cycle bit balance counter: ones/zeros/diff per word,
// plus a saturating running disparity across words.
module bit_balance_counter
    import bit_balance_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4,
    parameter int ACC_W = 16
) (
    input logic               clk,
    input logic               rst_n,
    bit_balance_counter_if.slave bus
);

    localparam int CW  = cnt_w(WIDTH);
    localparam int PW  = cnt_w(CHUNK);
    localparam int NCH = WIDTH / CHUNK;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int SW  = ((ACC_W > CW) ? ACC_W : CW) + 2;

    localparam logic [IW-1:0] LAST = IW'(NCH - 1);
    localparam logic signed [SW-1:0] MAXV =
        SW'((longint'(1) << (ACC_W - 1)) - 1);
    localparam logic signed [SW-1:0] MINV =
        SW'(-(longint'(1) << (ACC_W - 1)));

    if (WIDTH < 2) begin : g_bad_width
        $error("WIDTH must be at least 2");
    end
    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
        $error("WIDTH must be a multiple of CHUNK");
    end
    if (ACC_W < 4) begin : g_bad_acc
        $error("ACC_W must be at least 4");
    end

    state_e                  state_q, state_d;
    logic [WIDTH-1:0]        data_q;
    logic [CW-1:0]           part_q;
    logic [IW-1:0]           idx_q;
    logic [CW-1:0]           ones_q, zeros_q, diff_q;
    logic                    zgt_q;
    logic signed [ACC_W-1:0] disp_q;
    logic                    sat_q;

    logic [PW-1:0]           pc;
    logic                    accept, finish;
    logic [CW-1:0]           ones_d, zeros_d, diff_d;
    logic                    zgt_d;
    logic signed [SW-1:0]    delta, sum;
    logic signed [ACC_W-1:0] disp_d;
    logic                    clip;

    popcount_chunk #(
        .CHUNK (CHUNK),
        .PW    (PW)
    ) u_pc (
        .bits_i (data_q[CHUNK-1:0]),
        .cnt_o  (pc)
    );

    assign accept = bus.in_valid && (state_q == IDLE);
    assign finish = (state_q == BUSY) && (idx_q == LAST);

    // Next-state logic of the control FSM.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = BUSY;
            BUSY:    if (idx_q == LAST) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Word statistics and the clamped disparity update.
    always_comb begin
        ones_d  = part_q + CW'(pc);
        zeros_d = CW'(WIDTH) - ones_d;
        zgt_d   = zeros_d > ones_d;
        diff_d  = zgt_d ? (zeros_d - ones_d) : (ones_d - zeros_d);
        delta   = $signed(SW'(ones_d)) - $signed(SW'(zeros_d));
        sum     = SW'(disp_q) + delta;
        clip    = 1'b0;
        disp_d  = ACC_W'(sum);
        if (sum > MAXV) begin
            disp_d = ACC_W'(MAXV);
            clip   = 1'b1;
        end else if (sum < MINV) begin
            disp_d = ACC_W'(MINV);
            clip   = 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Latch the word and walk it one chunk per cycle, LSB first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q <= '0;
            part_q <= '0;
            idx_q  <= '0;
        end else if (accept) begin
            data_q <= bus.in_data;
            part_q <= '0;
            idx_q  <= '0;
        end else if (state_q == BUSY) begin
            data_q <= data_q >> CHUNK;
            part_q <= ones_d;
            idx_q  <= idx_q + 1'b1;
        end
    end

    // Published results change only when a word completes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ones_q  <= '0;
            zeros_q <= '0;
            diff_q  <= '0;
            zgt_q   <= 1'b0;
        end else if (finish) begin
            ones_q  <= ones_d;
            zeros_q <= zeros_d;
            diff_q  <= diff_d;
            zgt_q   <= zgt_d;
        end
    end

    // Running disparity; a clear beats a same-cycle update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            disp_q <= '0;
            sat_q  <= 1'b0;
        end else if (bus.clr_acc) begin
            disp_q <= '0;
            sat_q  <= 1'b0;
        end else if (finish) begin
            disp_q <= disp_d;
            if (clip) sat_q <= 1'b1;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.ones      = ones_q;
    assign bus.zeros     = zeros_q;
    assign bus.diff      = diff_q;
    assign bus.zeros_gt  = zgt_q;
    assign bus.run_disp  = disp_q;
    assign bus.sat       = sat_q;

endmodule

// File: tb/tb_bit_balance_counter.sv
// Directed bench: three configurations share one clock;
// index 0 = 16/4/16, 1 = 16/4/6, 2 = 16/16/16.
module tb_bit_balance_counter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  vld;
    logic [15:0] dat;
    logic        orr;
    logic        clr;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    bit_balance_counter_if #(.WIDTH(16), .ACC_W(16)) ifa ();
    bit_balance_counter_if #(.WIDTH(16), .ACC_W(6))  ifb ();
    bit_balance_counter_if #(.WIDTH(16), .ACC_W(16)) ifc ();

    bit_balance_counter #(.WIDTH(16), .CHUNK(4), .ACC_W(16)) u_a (
        .clk (clk), .rst_n (rst_n), .bus (ifa.slave)
    );
    bit_balance_counter #(.WIDTH(16), .CHUNK(4), .ACC_W(6)) u_b (
        .clk (clk), .rst_n (rst_n), .bus (ifb.slave)
    );
    bit_balance_counter #(.WIDTH(16), .CHUNK(16), .ACC_W(16)) u_c (
        .clk (clk), .rst_n (rst_n), .bus (ifc.slave)
    );

    assign ifa.in_valid  = vld[0];
    assign ifb.in_valid  = vld[1];
    assign ifc.in_valid  = vld[2];
    assign ifa.in_data   = dat;
    assign ifb.in_data   = dat;
    assign ifc.in_data   = dat;
    assign ifa.out_ready = orr;
    assign ifb.out_ready = orr;
    assign ifc.out_ready = orr;
    assign ifa.clr_acc   = clr;
    assign ifb.clr_acc   = clr;
    assign ifc.clr_acc   = clr;

    logic        ov [3];
    logic        ir [3];
    logic        zg [3];
    logic        st [3];
    logic [4:0]  on [3];
    logic [4:0]  ze [3];
    logic [4:0]  df [3];
    logic signed [63:0] ds [3];

    always_comb begin
        ov[0] = ifa.out_valid; ov[1] = ifb.out_valid; ov[2] = ifc.out_valid;
        ir[0] = ifa.in_ready;  ir[1] = ifb.in_ready;  ir[2] = ifc.in_ready;
        zg[0] = ifa.zeros_gt;  zg[1] = ifb.zeros_gt;  zg[2] = ifc.zeros_gt;
        st[0] = ifa.sat;       st[1] = ifb.sat;       st[2] = ifc.sat;
        on[0] = ifa.ones;      on[1] = ifb.ones;      on[2] = ifc.ones;
        ze[0] = ifa.zeros;     ze[1] = ifb.zeros;     ze[2] = ifc.zeros;
        df[0] = ifa.diff;      df[1] = ifb.diff;      df[2] = ifc.diff;
        ds[0] = 64'(ifa.run_disp);
        ds[1] = 64'(ifb.run_disp);
        ds[2] = 64'(ifc.run_disp);
    end

    task automatic chk(input string tag,
                       input logic signed [63:0] got,
                       input logic signed [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns cycles from accept edge to out_valid.
    task automatic send(input int s, input logic [15:0] w,
                        output int lat);
        vld[s] = 1'b1;
        dat    = w;
        @(negedge clk);
        vld[s] = 1'b0;
        lat    = 0;
        while (!ov[s] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic drain();
        orr = 1'b1;
        @(negedge clk);
        orr = 1'b0;
    endtask

    task automatic res(input int s, input string tag,
                       input int e_on, input int e_ze, input int e_df,
                       input int e_zg, input int e_ds, input int e_st);
        chk({tag, "_ones"}, 64'(on[s]), 64'(e_on));
        chk({tag, "_zeros"}, 64'(ze[s]), 64'(e_ze));
        chk({tag, "_diff"}, 64'(df[s]), 64'(e_df));
        chk({tag, "_zgt"}, 64'(zg[s]), 64'(e_zg));
        chk({tag, "_disp"}, ds[s], 64'(e_ds));
        chk({tag, "_sat"}, 64'(st[s]), 64'(e_st));
    endtask

    initial begin
        int lat;
        int seen;
        rst_n = 1'b0;
        vld   = '0;
        dat   = '0;
        orr   = 1'b0;
        clr   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ov", 64'(ov[0]), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ir", 64'(ir[0]), 1);
        res(0, "rst", 0, 0, 0, 0, 0, 0);

        send(0, 16'h7FFF, lat);
        chk("w1_lat", 64'(lat), 4);
        chk("w1_ir", 64'(ir[0]), 0);
        res(0, "w1", 15, 1, 14, 0, 14, 0);

        for (int i = 0; i < 3; i++) begin
            vld[0] = (i == 1);
            dat    = 16'h0000;
            @(negedge clk);
            chk("hold_ov", 64'(ov[0]), 1);
            chk("hold_ir", 64'(ir[0]), 0);
            chk("hold_ones", 64'(on[0]), 15);
            chk("hold_disp", ds[0], 14);
        end
        vld[0] = 1'b0;
        drain();
        chk("rel_ov", 64'(ov[0]), 0);
        chk("rel_ir", 64'(ir[0]), 1);
        chk("rel_ones", 64'(on[0]), 15);

        send(0, 16'h0000, lat);
        chk("w2_lat", 64'(lat), 4);
        res(0, "w2", 0, 16, 16, 1, -2, 0);
        drain();

        send(0, 16'h00FF, lat);
        res(0, "w3", 8, 8, 0, 0, -2, 0);
        drain();

        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_disp", ds[0], 0);

        vld[0] = 1'b1;
        dat    = 16'hFFFF;
        @(negedge clk);
        vld[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        repeat (6) begin
            @(negedge clk);
            if (ov[0]) seen++;
        end
        chk("abort_ov", 64'(seen), 0);
        chk("abort_disp", ds[0], 0);
        chk("abort_ir", 64'(ir[0]), 1);
        chk("abort_ones", 64'(on[0]), 0);

        vld[0] = 1'b1;
        dat    = 16'h7FFF;
        @(negedge clk);
        vld[0] = 1'b0;
        repeat (3) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("coin_ov", 64'(ov[0]), 1);
        chk("coin_ones", 64'(on[0]), 15);
        chk("coin_disp", ds[0], 0);
        drain();

        send(1, 16'hFFFF, lat);
        chk("s1_lat", 64'(lat), 4);
        res(1, "s1", 16, 0, 16, 0, 16, 0);
        drain();
        send(1, 16'hFFFF, lat);
        res(1, "s2", 16, 0, 16, 0, 31, 1);
        drain();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("s3_disp", ds[1], 0);
        chk("s3_sat", 64'(st[1]), 0);

        send(2, 16'h7FFF, lat);
        chk("c1_lat", 64'(lat), 1);
        res(2, "c1", 15, 1, 14, 0, 14, 0);
        drain();
        chk("c1_ir", 64'(ir[2]), 1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nerr);
        $finish;
    end

endmodule
